clock_divider_multi: RTL and testbench

Parametrised, multi-channel successor to the single-channel clock divider. Each of CHANNELS independent channels divides clk_in by a programmable period. Each channel has a programmable high time (duty) or a single-cycle pulse mode. Divider settings are shadow-registered and reloaded only at period boundaries, so changes never glitch the output; a shared sync input phase-aligns all channels.

---
 rtl/clock_divider_multi.sv | 78 +++++++
 tb/tb_clock_divider_multi.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_multi.sv
// rtl/clock_divider_multi.sv - multi-channel programmable clock divider with shadowed settings
module clock_divider_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
) (
  input  logic                      clk_in,
  input  logic                      nrst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] scale,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic [CHANNELS-1:0]       mode,
  input  logic                      sync,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       tick
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // live per-channel settings, sampled into the shadows only at safe points
    logic [WIDTH-1:0] live_scale;
    logic [WIDTH-1:0] live_duty;
    logic             live_mode;

    // running state and shadow copies of the settings for the current period
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] d_q;
    logic             m_q;
    logic             out_q;
    logic             tick_q;

    // wrap marks the last count of the period; level is the output for this count
    logic             wrap;
    logic             level;

    assign live_scale = scale[i*WIDTH +: WIDTH];
    assign live_duty  = duty[i*WIDTH +: WIDTH];
    assign live_mode  = mode[i];

    assign wrap  = (cnt_q == s_q);
    assign level = m_q ? wrap : (cnt_q < d_q);

    // counter, shadow reload and registered outputs for one channel
    always_ff @(posedge clk_in) begin
      if (!nrst) begin
        cnt_q  <= '0;
        s_q    <= '0;
        d_q    <= '0;
        m_q    <= 1'b0;
        out_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (sync || !en[i]) begin
        // idle or phase-align: park at count 0 and track the live settings
        cnt_q  <= '0;
        out_q  <= 1'b0;
        tick_q <= 1'b0;
        s_q    <= live_scale;
        d_q    <= live_duty;
        m_q    <= live_mode;
      end else begin
        out_q  <= level;
        tick_q <= wrap;
        if (wrap) begin
          // settings change only here, so a period is never cut short
          cnt_q <= '0;
          s_q   <= live_scale;
          d_q   <= live_duty;
          m_q   <= live_mode;
        end else begin
          cnt_q <= cnt_q + WIDTH'(1);
        end
      end
    end

    assign clk_out[i] = out_q;
    assign tick[i]    = tick_q;
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// tb/tb_clock_divider_multi.sv - directed self-checking bench for clock_divider_multi
module tb_clock_divider_multi;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 2;

  logic                      clk_in;
  logic                      nrst;
  logic [CHANNELS-1:0]       en;
  logic [CHANNELS*WIDTH-1:0] scale;
  logic [CHANNELS*WIDTH-1:0] duty;
  logic [CHANNELS-1:0]       mode;
  logic                      sync;
  logic [CHANNELS-1:0]       clk_out;
  logic [CHANNELS-1:0]       tick;

  int tests_run;
  int tests_failed;

  clock_divider_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk_in  (clk_in),
    .nrst    (nrst),
    .en      (en),
    .scale   (scale),
    .duty    (duty),
    .mode    (mode),
    .sync    (sync),
    .clk_out (clk_out),
    .tick    (tick)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // one rising edge, then settle so outputs reflect that edge
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_ch(input int ch, input int s, input int d, input logic m);
    scale[ch*WIDTH +: WIDTH] = WIDTH'(s);
    duty[ch*WIDTH +: WIDTH]  = WIDTH'(d);
    mode[ch]                 = m;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    en   = '0;
    sync = 1'b0;
    step();
    step();
    tests_run++;
    if (clk_out !== 2'b00 || tick !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_hold: clk_out=%b tick=%b required 00/00", clk_out, tick);
    end
    nrst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      tests_run++;
      if (clk_out !== 2'b00 || tick !== 2'b00) begin
        tests_failed++;
        $display("FAIL idle_%0d: clk_out=%b tick=%b required 00/00", k, clk_out, tick);
      end
    end
  endtask

  task automatic test_duty();
    logic [3:0] exp_clk;
    logic [3:0] exp_tick;
    exp_clk  = 4'b0011;   // cnt 0,1,2,3 -> 1,1,0,0
    exp_tick = 4'b1000;   // tick on cnt == 3
    set_ch(0, 3, 2, 1'b0);
    en = 2'b00;
    step();
    en = 2'b01;
    for (int k = 0; k < 12; k++) begin
      step();
      tests_run++;
      if (clk_out[0] !== exp_clk[k%4] || tick[0] !== exp_tick[k%4] || clk_out[1] !== 1'b0) begin
        tests_failed++;
        $display("FAIL duty_%0d: clk_out=%b tick=%b required clk0=%b tick0=%b clk1=0",
                 k, clk_out, tick, exp_clk[k%4], exp_tick[k%4]);
      end
    end
  endtask

  task automatic test_pulse();
    logic exp;
    en = 2'b00;
    set_ch(1, 4, 0, 1'b1);
    step();
    en = 2'b10;
    for (int k = 0; k < 15; k++) begin
      step();
      exp = ((k % 5) == 4);
      tests_run++;
      if (clk_out[1] !== exp || tick[1] !== exp) begin
        tests_failed++;
        $display("FAIL pulse_%0d: clk1=%b tick1=%b required %b/%b", k, clk_out[1], tick[1], exp, exp);
      end
    end
    // duty above scale holds the output high
    en = 2'b00;
    set_ch(1, 5, 9, 1'b0);
    step();
    en = 2'b10;
    for (int k = 0; k < 12; k++) begin
      step();
      exp = ((k % 6) == 5);
      tests_run++;
      if (clk_out[1] !== 1'b1 || tick[1] !== exp) begin
        tests_failed++;
        $display("FAIL duty_over_%0d: clk1=%b tick1=%b required 1/%b", k, clk_out[1], tick[1], exp);
      end
    end
  endtask

  task automatic test_reload();
    logic [9:0] exp_clk;
    logic [9:0] exp_tick;
    exp_clk  = 10'b0101010011;
    exp_tick = 10'b1010101000;
    en = 2'b00;
    set_ch(0, 3, 2, 1'b0);
    step();
    en = 2'b01;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 0) set_ch(0, 1, 1, 1'b0);   // change while cnt == 1
      tests_run++;
      if (clk_out[0] !== exp_clk[k] || tick[0] !== exp_tick[k]) begin
        tests_failed++;
        $display("FAIL reload_%0d: clk0=%b tick0=%b required %b/%b",
                 k, clk_out[0], tick[0], exp_clk[k], exp_tick[k]);
      end
    end
  endtask

  task automatic test_sync();
    logic e_clk0, e_clk1, e_t0, e_t1;
    en = 2'b00;
    set_ch(0, 3, 2, 1'b0);
    set_ch(1, 5, 3, 1'b0);
    step();
    en = 2'b01;
    step();
    step();
    en = 2'b11;
    step();
    step();
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    tests_run++;
    if (clk_out !== 2'b00 || tick !== 2'b00) begin
      tests_failed++;
      $display("FAIL sync_edge: clk_out=%b tick=%b required 00/00", clk_out, tick);
    end
    for (int k = 1; k <= 24; k++) begin
      step();
      e_clk0 = (((k - 1) % 4) < 2);
      e_clk1 = (((k - 1) % 6) < 3);
      e_t0   = ((k % 4) == 0);
      e_t1   = ((k % 6) == 0);
      tests_run++;
      if (clk_out !== {e_clk1, e_clk0} || tick !== {e_t1, e_t0}) begin
        tests_failed++;
        $display("FAIL sync_after_%0d: clk_out=%b tick=%b required %b/%b",
                 k, clk_out, tick, {e_clk1, e_clk0}, {e_t1, e_t0});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] exp_clk;
    logic [4:0] exp_tick;
    // shadows are cleared by reset, so the first period runs with S=0, D=0
    exp_clk  = 5'b00110;
    exp_tick = 5'b10001;
    en = 2'b00;
    set_ch(0, 3, 2, 1'b0);
    step();
    en = 2'b01;
    step();
    step();
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    tests_run++;
    if (clk_out !== 2'b00 || tick !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_mid: clk_out=%b tick=%b required 00/00", clk_out, tick);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      tests_run++;
      if (clk_out[0] !== exp_clk[k] || tick[0] !== exp_tick[k]) begin
        tests_failed++;
        $display("FAIL after_reset_%0d: clk0=%b tick0=%b required %b/%b",
                 k, clk_out[0], tick[0], exp_clk[k], exp_tick[k]);
      end
    end
  endtask

  task automatic test_boundary();
    logic e_clk, e_tick;
    int   bad;
    // full-range period: 256 cycles, 128 high
    en = 2'b00;
    set_ch(0, 255, 128, 1'b0);
    step();
    en = 2'b01;
    bad = 0;
    for (int k = 0; k < 512; k++) begin
      step();
      e_clk  = ((k % 256) < 128);
      e_tick = ((k % 256) == 255);
      if (clk_out[0] !== e_clk || tick[0] !== e_tick) begin
        if (bad < 4)
          $display("FAIL full_range_%0d: clk0=%b tick0=%b required %b/%b",
                   k, clk_out[0], tick[0], e_clk, e_tick);
        bad++;
      end
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL full_range_total: %0d bad cycles, required 0", bad);
    end
    // scale 0: tick always high; output depends on mode and duty
    en = 2'b00;
    set_ch(0, 0, 0, 1'b0);
    set_ch(1, 0, 0, 1'b1);
    step();
    en = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      tests_run++;
      if (clk_out !== 2'b10 || tick !== 2'b11) begin
        tests_failed++;
        $display("FAIL scale0_%0d: clk_out=%b tick=%b required 10/11", k, clk_out, tick);
      end
    end
    set_ch(0, 0, 1, 1'b0);
    step();   // reload happens at this wrap
    for (int k = 0; k < 3; k++) begin
      step();
      tests_run++;
      if (clk_out !== 2'b11 || tick !== 2'b11) begin
        tests_failed++;
        $display("FAIL scale0_duty1_%0d: clk_out=%b tick=%b required 11/11", k, clk_out, tick);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    nrst  = 1'b0;
    en    = '0;
    scale = '0;
    duty  = '0;
    mode  = '0;
    sync  = 1'b0;
    test_reset();
    test_duty();
    test_pulse();
    test_reload();
    test_sync();
    test_reset_mid();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
